// File: rtl/min_max_dist_engine_pkg.sv
// Shared types and constants for the min/max pairwise distance engine.
package min_max_pkg;
    localparam int N_VALS      = 32;
    localparam int N_PAIRS     = 496;
    localparam int LOAD_CYCLES = 65;
    localparam int MIN_BYTE    = 66;
    localparam int MAX_BYTE    = 68;

    typedef enum logic [2:0] {IDLE, ARMED, LOAD, COMPARE, WRITE, DONE} state_t;
    typedef logic [4:0] idx_t;
endpackage

// File: rtl/min_max_dist_engine_abs_dist.sv
// Combinational |a-b| of two signed 16-bit operands; the 17-bit difference
// keeps the full range so the magnitude fits 0..65535 without overflow.
module abs_dist (
    input  logic signed [15:0] i_a,
    input  logic signed [15:0] i_b,
    output logic        [15:0] o_dist
);
    logic signed [16:0] w_diff;
    logic        [16:0] w_mag;

    assign w_diff = {i_a[15], i_a} - {i_b[15], i_b};
    assign w_mag  = w_diff[16] ? 17'(-w_diff) : w_diff;
    assign o_dist = w_mag[15:0];
endmodule

// File: rtl/min_max_dist_engine.sv
// Start/done responder: loads 32 signed words from byte memory, scans all
// unordered pairs for min/max absolute difference, writes results back.
module min_max_dist_engine
    import min_max_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int MIN_ADDR = MIN_BYTE,
    parameter int MAX_ADDR = MAX_BYTE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic [15:0]       min_dist,
    output logic [15:0]       max_dist,
    output logic [9:0]        min_pair,
    output logic [9:0]        max_pair
);
    state_t             r_state, w_next;
    logic [6:0]         r_cnt;
    idx_t               r_j, r_k;
    logic [15:0]        r_min, r_max;
    logic [9:0]         r_min_pair, r_max_pair;
    logic signed [15:0] r_rf [N_VALS];
    logic [15:0]        w_dist;
    logic [5:0]         w_cap;

    abs_dist u_abs_dist (
        .i_a    (r_rf[r_j]),
        .i_b    (r_rf[r_k]),
        .o_dist (w_dist)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = ARMED;
            ARMED:   if (!start) w_next = LOAD;
            LOAD:    if (r_cnt == 7'(LOAD_CYCLES - 1)) w_next = COMPARE;
            COMPARE: if (r_j == 5'd30 && r_k == 5'd31) w_next = WRITE;
            WRITE:   if (r_cnt[1:0] == 2'd3) w_next = DONE;
            DONE:    if (start) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (r_state == LOAD && !r_cnt[6]) begin
            mem_addr = ADDR_W'(r_cnt[5:0]);
        end else if (r_state == WRITE) begin
            mem_we = 1'b1;
            case (r_cnt[1:0])
                2'd0:    begin mem_addr = ADDR_W'(MIN_ADDR);     mem_wdata = r_min[15:8]; end
                2'd1:    begin mem_addr = ADDR_W'(MIN_ADDR + 1); mem_wdata = r_min[7:0];  end
                2'd2:    begin mem_addr = ADDR_W'(MAX_ADDR);     mem_wdata = r_max[15:8]; end
                default: begin mem_addr = ADDR_W'(MAX_ADDR + 1); mem_wdata = r_max[7:0];  end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_j        <= '0;
            r_k        <= 5'd1;
            r_min      <= 16'hFFFF;
            r_max      <= '0;
            r_min_pair <= '0;
            r_max_pair <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ARMED: begin
                    r_cnt <= '0;
                    r_j   <= '0;
                    r_k   <= 5'd1;
                    // Pairs start at the first scanned pair so an all-equal set reports {0,1}.
                    if (!start) begin
                        r_min      <= 16'hFFFF;
                        r_max      <= '0;
                        r_min_pair <= {5'd0, 5'd1};
                        r_max_pair <= {5'd0, 5'd1};
                    end
                end
                LOAD:    r_cnt <= (r_cnt == 7'(LOAD_CYCLES - 1)) ? 7'd0 : r_cnt + 7'd1;
                COMPARE: begin
                    if (r_k == 5'd31) begin
                        r_j <= r_j + 5'd1;
                        r_k <= r_j + 5'd2;
                    end else begin
                        r_k <= r_k + 5'd1;
                    end
                    if (w_dist < r_min) begin
                        r_min      <= w_dist;
                        r_min_pair <= {r_j, r_k};
                    end
                    if (w_dist > r_max) begin
                        r_max      <= w_dist;
                        r_max_pair <= {r_j, r_k};
                    end
                end
                WRITE:   r_cnt <= r_cnt + 7'd1;
                default: ;
            endcase
        end
    end

    // Read data lags the address by one cycle, so count N captures byte N-1.
    assign w_cap = r_cnt[5:0] - 6'd1;

    always_ff @(posedge clk) begin
        if (r_state == LOAD && r_cnt != 7'd0) begin
            if (!w_cap[0]) r_rf[w_cap[5:1]][15:8] <= mem_rdata;
            else           r_rf[w_cap[5:1]][7:0]  <= mem_rdata;
        end
    end

    assign done     = (r_state == DONE);
    assign min_dist = r_min;
    assign max_dist = r_max;
    assign min_pair = r_min_pair;
    assign max_pair = r_max_pair;
endmodule

// File: tb/tb_min_max_dist_engine.sv
// Scoreboard bench for min_max_dist_engine with a byte-wide memory model.
module tb_min_max_dist_engine;
    logic       clk = 1'b0;
    logic       rst_n, start, done, mem_we;
    logic [7:0] mem_addr, mem_rdata, mem_wdata;
    logic [15:0] min_dist, max_dist;
    logic [9:0]  min_pair, max_pair;

    logic [7:0] mem [256];
    logic       tb_we = 1'b0;
    logic [7:0] tb_addr = '0, tb_wdata = '0;
    int         wr_total = 0;
    int         cyc = 0;
    int         n_tests = 0, n_fail = 0;

    typedef struct {
        logic [15:0] mn;
        logic [15:0] mx;
        logic [9:0]  mnp;
        logic [9:0]  mxp;
        int          t0;
    } exp_t;
    exp_t q[$];

    logic [15:0] vals [32];

    min_max_dist_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .min_dist(min_dist), .max_dist(max_dist), .min_pair(min_pair), .max_pair(max_pair)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_total      <= wr_total + 1;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: write-window check every cycle, result check on each done rise.
    logic done_q = 1'b0;
    int   wr_mark = 0;
    exp_t e;
    always @(negedge clk) begin
        if (mem_we)
            check("we_addr_window", 32'(mem_addr >= 8'd66 && mem_addr <= 8'd69), 32'd1);
        if (done && !done_q) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("min_dist",    32'(min_dist), 32'(e.mn));
                check("max_dist",    32'(max_dist), 32'(e.mx));
                check("min_pair",    32'(min_pair), 32'(e.mnp));
                check("max_pair",    32'(max_pair), 32'(e.mxp));
                check("latency",     32'(cyc - e.t0), 32'd566);
                check("mem_min",     {16'd0, mem[66], mem[67]}, 32'(e.mn));
                check("mem_max",     {16'd0, mem[68], mem[69]}, 32'(e.mx));
                check("bytes_64_65", {16'd0, mem[64], mem[65]}, 32'h0000A55A);
                check("write_count", 32'(wr_total - wr_mark), 32'd4);
            end
            wr_mark = wr_total;
        end
        done_q = done;
    end

    task automatic tb_wr(input logic [7:0] a, input logic [7:0] d);
        tb_we = 1'b1; tb_addr = a; tb_wdata = d;
        @(posedge clk); #1;
    endtask

    task automatic load_vals();
        for (int i = 0; i < 32; i++) begin
            tb_wr(8'(2 * i),     vals[i][15:8]);
            tb_wr(8'(2 * i + 1), vals[i][7:0]);
        end
        tb_wr(8'd64, 8'hA5);
        tb_wr(8'd65, 8'h5A);
        for (int a = 66; a < 70; a++) tb_wr(8'(a), 8'hEE);
        tb_we = 1'b0;
    endtask

    task automatic start_run(input logic push, input logic [15:0] mn, input logic [15:0] mx,
                             input logic [9:0] mnp, input logic [9:0] mxp);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        if (push) q.push_back('{mn: mn, mx: mx, mnp: mnp, mxp: mxp, t0: cyc});
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_within_budget", 32'(done), 32'd1);
        @(negedge clk); #1;
    endtask

    int snap;

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done",     32'(done),      32'd0);
        check("rst_mem_we",   32'(mem_we),    32'd0);
        check("rst_mem_addr", 32'(mem_addr),  32'd0);
        check("rst_wdata",    32'(mem_wdata), 32'd0);
        check("rst_min",      32'(min_dist),  32'h0000FFFF);
        check("rst_max",      32'(max_dist),  32'd0);
        check("rst_pairs",    {12'd0, min_pair, max_pair}, 32'd0);
        rst_n = 1'b1;

        // Ramp i*3: min 3 at {0,1}, max 93 at {0,31}.
        for (int i = 0; i < 32; i++) vals[i] = 16'(i * 3);
        load_vals();
        start_run(1'b1, 16'd3, 16'd93, 10'd1, 10'd31);
        wait_done(1000);
        snap = wr_total;
        repeat (50) @(posedge clk);
        #1;
        check("done_held_start_low", 32'(done), 32'd1);
        check("no_second_run", 32'(wr_total - snap), 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        check("done_drops", 32'(done), 32'd0);

        // Extremes: -32768 vs 32767 -> 65535; first zero-distance pair is {1,2}.
        for (int i = 0; i < 32; i++) vals[i] = 16'h0000;
        vals[0]  = 16'h8000;
        vals[31] = 16'h7FFF;
        load_vals();
        start_run(1'b1, 16'd0, 16'hFFFF, {5'd1, 5'd2}, {5'd0, 5'd31});
        wait_done(1000);
        start = 1'b1;

        // All equal, start raised mid-run: tie rule and one-cycle done pulse.
        for (int i = 0; i < 32; i++) vals[i] = 16'h1234;
        load_vals();
        start_run(1'b1, 16'd0, 16'd0, 10'd1, 10'd1);
        repeat (300) @(posedge clk);
        #1;
        start = 1'b1;
        wait_done(1000);
        @(posedge clk); #1;
        check("done_one_cycle_pulse", 32'(done), 32'd0);

        // Reset at COMPARE cycle 200, released with start low.
        for (int i = 0; i < 32; i++) vals[i] = 16'(i * 100 - 1000);
        load_vals();
        start_run(1'b0, 16'd0, 16'd0, 10'd0, 10'd0);
        snap = wr_total;
        repeat (266) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_done",   32'(done),     32'd0);
        check("abort_mem_we", 32'(mem_we),   32'd0);
        check("abort_min",    32'(min_dist), 32'h0000FFFF);
        check("abort_max",    32'(max_dist), 32'd0);
        check("abort_pairs",  {12'd0, min_pair, max_pair}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (700) @(posedge clk);
        #1;
        check("no_run_after_reset_done", 32'(done), 32'd0);
        check("no_run_after_reset_min",  32'(min_dist), 32'h0000FFFF);
        check("no_writes_after_abort",   32'(wr_total - snap), 32'd0);
        start_run(1'b1, 16'd100, 16'd3100, 10'd1, 10'd31);
        wait_done(1000);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/min_max_dist_engine.md
Name: min_max_dist_engine

Overview:
- Hardware responder for the program-2 start/done handshake.
- On request, reads 32 signed 16-bit values from the shared byte-wide data memory (bytes 0..63).
- Finds the minimum and maximum absolute pairwise difference over all 496 unordered pairs.
- Writes both results back to bytes 66..69 and then raises done. It sits beside the data memory and owns its port while running.

Parameters:
N_VALS, 32, number of 16-bit operands (byte footprint 2*N_VALS)
ADDR_W, 8, data memory byte address width
MIN_ADDR, 66, byte address of Min high byte (low byte at MIN_ADDR+1)
MAX_ADDR, 68, byte address of Max high byte (low byte at MAX_ADDR+1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; a run begins on a 1->0 transition, and must be high again before the next run
done  out  1  acknowledge; high from completion until start returns high
mem_addr  out  ADDR_W  data memory byte address
mem_rdata  in  8  read data, valid the cycle after mem_addr is presented
mem_wdata  out  8  write data
mem_we  out  1  write enable, one byte per cycle
min_dist  out  16  final minimum distance
max_dist  out  16  final maximum distance
min_pair  out  10  {j[4:0],k[4:0]} indices of the minimum pair
max_pair  out  10  {j[4:0],k[4:0]} indices of the maximum pair

Behaviour:
- Reset (async, rst_n=0) drives these values:
  - state IDLE; done=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - min_dist=16'hFFFF, max_dist=0, min_pair=max_pair=0.
  - Reset mid-run aborts immediately; no further memory writes occur.
- Operand format: value i = signed {mem[2i], mem[2i+1]}, high byte first. Results use the same byte order.
- FSM:
  - IDLE: wait for start=1, then go to ARMED. This blocks a run when reset releases with start already low.
  - ARMED: start=0 -> LOAD. Clear running min to FFFF and max to 0.
  - LOAD: issue mem_addr=0..63 in cycles 0..63; capture mem_rdata one cycle later into a 32x16 register file. Lasts 65 cycles, then COMPARE.
  - COMPARE: one pair per cycle, j outer 0..30, k inner j+1..31. Lasts 496 cycles, then WRITE.
  - WRITE: four cycles with mem_we=1, writing MIN_ADDR, MIN_ADDR+1, MAX_ADDR, MAX_ADDR+1 with Min[15:8], Min[7:0], Max[15:8], Max[7:0]. Then DONE.
  - DONE: done=1 until start=1, then IDLE with done=0 in the following cycle.
- Latency: done rises exactly 565 cycles after the first LOAD cycle.
- Distance arithmetic:
  - diff = sign-extended 17-bit a-b; dist = diff[16] ? -diff : diff, truncated to 16 bits.
  - Range 0..65535; -32768 vs 32767 gives 65535, with no overflow.
- Update rules use strict comparison: dist<min replaces min, dist>max replaces max. Ties keep the first pair in scan order. Indices are stored as j (lower) and k (higher).
- Memory writes: mem_we is never asserted outside WRITE. Bytes 64,65 and 70..255 are never written. The operand region is never written.
- start changes during LOAD/COMPARE/WRITE are ignored; the run completes. If start is already high when DONE is entered, done still pulses for exactly one cycle.
- min_dist/max_dist/min_pair/max_pair hold their final values until the next ARMED->LOAD transition.

Decomposition:
- Package min_max_pkg holds:
  - state_t enum {IDLE, ARMED, LOAD, COMPARE, WRITE, DONE};
  - localparams N_VALS, N_PAIRS=496, LOAD_CYCLES=65, and the MIN/MAX byte addresses;
  - pair index typedef idx_t logic[4:0].
- One sub-module, abs_dist: combinational 16-bit signed |a-b| producing 16 bits, instanced once in COMPARE.
- The top level holds the FSM, counters, register file and write sequencer.

Test Plan:
- Values i*3 for i=0..31, start 1->0 -> mem[66:67]=0x0003, mem[68:69]=0x005D (93); done at cycle 565; bytes 64,65 untouched.
- value0=-32768, value31=32767, others 0 -> Min=0, Max=65535 (0xFFFF), max_pair={0,31}.
- All 32 values equal 0x1234 -> Min=0, Max=0, min_pair=max_pair={0,1} (first-pair tie rule).
- rst_n pulsed low during COMPARE cycle 200 -> done=0, outputs at reset values, no mem_we; the next start 1->0 completes correctly.
- Reset released with start=0 -> no run until start goes 1 then 0.
- Start held low after DONE -> done stays 1 with no second run; start high -> done drops next cycle.
